// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial LSB-first adder/subtractor built around one full-adder cell
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sel,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sel_q;
    logic             c_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res;

    logic bx;
    logic sum_bit;
    logic c_next;
    logic last_bit;
    logic accept;

    // Single full-adder cell; operands are shifted right so bit 0 is always the current bit
    always_comb begin
        bx       = b_q[0] ^ sel_q;
        sum_bit  = a_q[0] ^ bx ^ c_q;
        c_next   = (a_q[0] & bx) | (a_q[0] & c_q) | (bx & c_q);
        last_bit = (cnt == CW'(WIDTH - 1));
        accept   = start && ((state == IDLE) || (state == DONE));
    end

    // Control FSM, operand capture, serial datapath and result commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sel_q <= 1'b0;
            c_q   <= 1'b0;
            cnt   <= '0;
            res   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_q   <= a;
                        b_q   <= b;
                        sel_q <= sel;
                        c_q   <= cin ^ sel;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    a_q <= {1'b0, a_q[WIDTH-1:1]};
                    b_q <= {1'b0, b_q[WIDTH-1:1]};
                    c_q <= c_next;
                    res <= {sum_bit, res[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    if (last_bit) begin
                        // c_q here is the carry into the MSB, c_next the carry out of it
                        s     <= {sum_bit, res[WIDTH-1:1]};
                        cout  <= c_next;
                        ovf   <= c_q ^ c_next;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - directed self-checking bench for serial_addsub
module tb_serial_addsub;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sel;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             busy;
    logic             done;

    int checks;
    int failures;
    logic [WIDTH-1:0] prev_s;

    serial_addsub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sel   (sel),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s"}, 32'(s), 32'(0));
        chk({tag, "_cout"}, 32'(cout), 32'(0));
        chk({tag, "_ovf"}, 32'(ovf), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
    endtask

    // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge of the done cycle.
    // glitch_at >= 0 pulses start with junk operands at that SHIFT cycle.
    task automatic run_op(input string tag,
                          input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tcin, input logic tsel,
                          input logic [WIDTH-1:0] exp_s, input logic exp_cout,
                          input logic exp_ovf, input int glitch_at);
        start = 1'b1;
        a     = ta;
        b     = tb;
        cin   = tcin;
        sel   = tsel;
        @(negedge clk);
        start = 1'b0;
        a     = ~ta;
        b     = ~tb;
        cin   = ~tcin;
        sel   = ~tsel;
        for (int i = 0; i < WIDTH; i++) begin
            chk({tag, "_busy"}, 32'(busy), 32'(1));
            chk({tag, "_nodone"}, 32'(done), 32'(0));
            chk({tag, "_hold_s"}, 32'(s), 32'(prev_s));
            if (i == glitch_at) begin
                start = 1'b1;
                a     = 4'b0111;
                b     = 4'b0111;
                cin   = 1'b1;
                sel   = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'(1));
        chk({tag, "_notbusy"}, 32'(busy), 32'(0));
        chk({tag, "_s"}, 32'(s), 32'(exp_s));
        chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        prev_s = exp_s;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        prev_s   = '0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        sel      = 1'b0;
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // basic add with carry-in: 2 + 1 + 1 = 4
        run_op("add_cin", 4'b0010, 4'b0001, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, -1);
        @(negedge clk);
        chk("idle_after_done", 32'(done), 32'(0));
        chk("idle_after_busy", 32'(busy), 32'(0));
        chk("idle_hold_s", 32'(s), 32'(4'b0100));

        // subtract with borrow out: 3 - 6 = -3
        run_op("sub_borrow", 4'b0011, 4'b0110, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b0, -1);
        @(negedge clk);
        // signed overflow on add: 7 + 1
        run_op("add_ovf", 4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, -1);
        @(negedge clk);
        // unsigned carry, no signed overflow: -1 + 1
        run_op("add_carry", 4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, -1);
        @(negedge clk);
        // subtract with borrow-in: 5 - 2 - 1 = 2, no borrow
        run_op("sub_bin", 4'b0101, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 1'b0, -1);
        @(negedge clk);
        // signed overflow on subtract: -8 - 1
        run_op("sub_ovf", 4'b1000, 4'b0001, 1'b0, 1'b1, 4'b0111, 1'b1, 1'b1, -1);
        @(negedge clk);

        // start during SHIFT ignored, then back-to-back accept from DONE
        run_op("ignore", 4'b0010, 4'b0001, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 1);
        run_op("b2b", 4'b0011, 4'b0110, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b0, -1);
        @(negedge clk);
        chk("b2b_idle_done", 32'(done), 32'(0));

        // async reset mid-cycle with nonzero outputs
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst    = 1'b0;
        prev_s = '0;
        @(negedge clk);

        // reset on the 2nd SHIFT cycle of 5 + 3 aborts with no done pulse
        start = 1'b1;
        a     = 4'b0101;
        b     = 4'b0011;
        cin   = 1'b0;
        sel   = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy1", 32'(busy), 32'(1));
        @(negedge clk);
        chk("abort_busy2", 32'(busy), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            @(negedge clk);
            chk("abort_nodone", 32'(done), 32'(0));
            chk("abort_nobusy", 32'(busy), 32'(0));
        end
        run_op("rerun", 4'b0101, 4'b0011, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, -1);
        @(negedge clk);
        chk("final_idle", 32'(done), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
